kernel_call_sequencer: RTL

- Upstream driver for a generated kernel (r_enable / w_enable / result protocol, e.g. the 7-argument 64-bit adder).
- Collects NARGS argument words from a valid/ready stream and presents them on the kernel's argument ports.
- Issues a one-cycle start pulse and waits for the kernel's done edge.
- Returns the captured result downstream on a valid/ready stream, one call at a time.

---
 rtl/kernel_if_pkg.sv | 9 +
 rtl/kernel_done_detect.sv | 11 +
 rtl/kernel_call_sequencer.sv | 82 ++++++++
 3 files changed

// File: rtl/kernel_if_pkg.sv
// kernel_if_pkg: shared state encoding, default sizes and index-width helper for kernel drivers
package kernel_if_pkg;
   typedef enum logic [1:0] {COLLECT, FIRE, WAIT, HOLD} state_t;
   localparam int DEF_WIDTH = 64;
   localparam int DEF_NARGS = 7;
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/kernel_done_detect.sv
// kernel_done_detect: rising-edge pulse from a kernel done level; history starts high so a level held across reset is not an edge
module kernel_done_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic i_w_enable,
   output logic o_edge
);
   logic r_hist;
   always_ff @(posedge clk) r_hist <= !rst_n ? 1'b1 : i_w_enable;
   assign o_edge = i_w_enable & ~r_hist;
endmodule

// File: rtl/kernel_call_sequencer.sv
// kernel_call_sequencer: streams NARGS argument words into a kernel, pulses start, returns the result on done edge
module kernel_call_sequencer
   import kernel_if_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int NARGS   = DEF_NARGS,
   parameter int TIMEOUT = 4096
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_data,
   output logic [NARGS*WIDTH-1:0] k_args,
   output logic                   k_r_enable,
   input  logic                   k_w_enable,
   input  logic [WIDTH-1:0]       k_result,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_data,
   output logic                   busy,
   output logic                   timeout_err,
   output logic [31:0]            call_count
);
   localparam int IW = idx_width(NARGS);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [IW-1:0] LAST = IW'(NARGS - 1);
   localparam logic [CW-1:0] LIM  = CW'(TIMEOUT - 1);
   state_t r_state, w_next;
   logic [IW-1:0]          r_idx;
   logic [CW-1:0]          r_cnt;
   logic [NARGS*WIDTH-1:0] r_args;
   logic [WIDTH-1:0]       r_out;
   logic                   r_terr;
   logic [31:0]            r_calls;
   logic                   w_edge, w_accept, w_done, w_expire;
   kernel_done_detect u_done (.clk(clk), .rst_n(rst_n), .i_w_enable(k_w_enable), .o_edge(w_edge));
   assign w_accept = in_valid & in_ready;
   assign w_done   = (r_state == WAIT) & w_edge;
   assign w_expire = (r_state == WAIT) & ~w_edge & (r_cnt == LIM);
   always_ff @(posedge clk) r_state <= !rst_n ? COLLECT : w_next;
   always_comb begin
      w_next = r_state;
      case (r_state)
         COLLECT: w_next = (w_accept && r_idx == LAST) ? FIRE : COLLECT;
         FIRE:    w_next = WAIT;
         WAIT:    w_next = w_done ? HOLD : (w_expire ? COLLECT : WAIT);
         HOLD:    w_next = out_ready ? COLLECT : HOLD;
         default: w_next = COLLECT;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_idx   <= '0;
         r_cnt   <= '0;
         r_args  <= '0;
         r_out   <= '0;
         r_terr  <= 1'b0;
         r_calls <= '0;
      end else begin
         if (w_accept) begin
            r_args[r_idx*WIDTH +: WIDTH] <= in_data;
            r_idx <= (r_idx == LAST) ? '0 : r_idx + 1'b1;
         end
         if (r_state == FIRE) r_cnt <= '0;
         else if (r_state == WAIT) r_cnt <= r_cnt + 1'b1;
         if (w_done) begin
            r_out   <= k_result;
            r_calls <= r_calls + 32'd1;
         end
         if (w_expire) r_terr <= 1'b1;
      end
   end
   assign in_ready    = r_state == COLLECT;
   assign k_r_enable  = r_state == FIRE;
   assign out_valid   = r_state == HOLD;
   assign busy        = !(r_state == COLLECT && r_idx == '0);
   assign k_args      = r_args;
   assign out_data    = r_out;
   assign timeout_err = r_terr;
   assign call_count  = r_calls;
endmodule
